// File: rtl/fu_alu_pipe.sv
// Pipelined integer ALU functional unit: compute in stage 0, then elastic register slices.
// Accepts one op per cycle under valid/ready and returns result, flags and tag after STAGES cycles.
module fu_alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] port_output,
    output logic             negative,
    output logic             overflow,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SH_W = $clog2(WIDTH);

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("fu_alu_pipe: STAGES must be in 1..4");
        end
    endgenerate

    function automatic logic signed [WIDTH-1:0] alu_result(
        input logic [3:0]              op,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (op)
            4'd0:    alu_result = a << sh;
            4'd1:    alu_result = $unsigned(a) >> sh;
            4'd2:    alu_result = a + b;
            4'd3:    alu_result = a - b;
            4'd4:    alu_result = a & b;
            4'd5:    alu_result = a | b;
            4'd6:    alu_result = a ^ b;
            4'd7:    alu_result = ~(a | b);
            4'd8:    alu_result = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd9:    alu_result = {{(WIDTH-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
            4'd10:   alu_result = a >>> sh;
            default: alu_result = '0;
        endcase
    endfunction

    function automatic logic alu_overflow(
        input logic [3:0]              op,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input logic signed [WIDTH-1:0] r
    );
        case (op)
            4'd2:    alu_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            4'd3:    alu_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            default: alu_overflow = 1'b0;
        endcase
    endfunction

    logic signed [WIDTH-1:0] opa_s, opb_s, res_c;
    logic                    ovf_c;

    logic [STAGES-1:0]       vld;
    logic [STAGES-1:0]       ld;
    logic signed [WIDTH-1:0] res_q [STAGES];
    logic                    neg_q [STAGES];
    logic                    ovf_q [STAGES];
    logic                    zro_q [STAGES];
    logic [TAG_W-1:0]        tag_q [STAGES];

    assign opa_s = port_a;
    assign opb_s = port_b;
    assign res_c = alu_result(aluop, opa_s, opb_s);
    assign ovf_c = alu_overflow(aluop, opa_s, opb_s, res_c);

    // A stage can load if it or any stage downstream of it holds a bubble, or the output drains.
    always_comb begin
        logic room;
        ld   = '0;
        room = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            room  = room | ~vld[i];
            ld[i] = room;
        end
    end

    assign in_ready = ld[0];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
                neg_q[i] <= 1'b0;
                ovf_q[i] <= 1'b0;
                zro_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                vld <= '0;
            end else begin
                if (ld[0]) vld[0] <= in_valid;
                for (int i = 1; i < STAGES; i++) begin
                    if (ld[i]) vld[i] <= vld[i-1];
                end
            end
            // Stage 0: register the ALU result with its flags
            if (!flush && ld[0] && in_valid) begin
                res_q[0] <= res_c;
                neg_q[0] <= res_c[WIDTH-1];
                ovf_q[0] <= ovf_c;
                zro_q[0] <= (res_c == '0);
                tag_q[0] <= in_tag;
            end
            // Stages 1..STAGES-1: elastic slices, data moves only with a valid op
            for (int i = 1; i < STAGES; i++) begin
                if (!flush && ld[i] && vld[i-1]) begin
                    res_q[i] <= res_q[i-1];
                    neg_q[i] <= neg_q[i-1];
                    ovf_q[i] <= ovf_q[i-1];
                    zro_q[i] <= zro_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end
    end

    assign out_valid   = vld[STAGES-1];
    assign port_output = res_q[STAGES-1];
    assign negative    = neg_q[STAGES-1];
    assign overflow    = ovf_q[STAGES-1];
    assign zero        = zro_q[STAGES-1];
    assign out_tag     = tag_q[STAGES-1];

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Scoreboard bench for fu_alu_pipe (WIDTH=32, STAGES=2): directed ops, backpressure, flush, reset.
module tb_fu_alu_pipe;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TW = 5;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    aluop = '0;
    logic [W-1:0]  port_a = '0;
    logic [W-1:0]  port_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  port_output;
    logic          negative, overflow, zero;
    logic [TW-1:0] out_tag;

    fu_alu_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .port_a(port_a), .port_b(port_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .port_output(port_output), .negative(negative), .overflow(overflow),
        .zero(zero), .out_tag(out_tag)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic          n;
        logic          o;
        logic          z;
        logic          chk;
        logic [31:0]   cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Present one op, wait (bounded) for in_ready, push its expectation on the accepting edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input logic [W-1:0] r,
                        input logic n, input logic o, input logic z, input logic chk);
        exp_t e;
        int   waited;
        waited   = 0;
        aluop    = op;
        port_a   = a;
        port_b   = b;
        in_tag   = tag;
        in_valid = 1'b1;
        @(negedge CLK);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge CLK);
        end
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            e.tag = tag; e.res = r; e.n = n; e.o = o; e.z = z; e.chk = chk;
            e.cyc = cyc;
            @(posedge CLK);
            sb.push_back(e);
            #1;
        end
    endtask

    // Monitor: compares every consumed result and checks outputs hold while stalled.
    exp_t          m_e;
    logic          stall = 1'b0;
    logic [63:0]   held = '0;

    always @(negedge CLK) begin
        if (!nRST || !out_valid) begin
            stall <= 1'b0;
        end else begin
            if (stall)
                check("hold_stable", {port_output, negative, overflow, zero, out_tag}, held);
            if (out_ready) begin
                stall <= 1'b0;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: tag %0d emerged, expected none", out_tag);
                end else begin
                    m_e = sb.pop_front();
                    check($sformatf("tag[%0d]", m_e.tag), 64'(out_tag), 64'(m_e.tag));
                    check($sformatf("result[tag %0d]", m_e.tag), 64'(port_output), 64'(m_e.res));
                    check($sformatf("flags_nvz[tag %0d]", m_e.tag), {61'd0, negative, overflow, zero},
                          {61'd0, m_e.n, m_e.o, m_e.z});
                    if (m_e.chk)
                        check($sformatf("latency[tag %0d]", m_e.tag), 64'(cyc - m_e.cyc), 64'(S));
                end
            end else begin
                stall <= 1'b1;
                held  <= {24'd0, port_output, negative, overflow, zero, out_tag};
            end
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_out_valid"}, 64'(out_valid), 64'd0);
        check({name, "_data"}, {port_output, negative, overflow, zero, out_tag}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge CLK); #1;

        // Directed ops, back-to-back, out_ready held high
        send(4'd2,  32'h7FFFFFFF, 32'h00000001, 5'd1,  32'h80000000, 1, 1, 0, 1);
        send(4'd3,  32'h00000005, 32'h00000005, 5'd2,  32'h00000000, 0, 0, 1, 1);
        send(4'd8,  32'hFFFFFFFF, 32'h00000001, 5'd3,  32'h00000001, 0, 0, 0, 1);
        send(4'd9,  32'hFFFFFFFF, 32'h00000001, 5'd4,  32'h00000000, 0, 0, 1, 1);
        send(4'd10, 32'h80000000, 32'h0000003F, 5'd5,  32'hFFFFFFFF, 1, 0, 0, 1);
        send(4'd1,  32'h80000000, 32'h0000003F, 5'd6,  32'h00000001, 0, 0, 0, 1);
        send(4'd0,  32'h00000001, 32'h00000020, 5'd7,  32'h00000001, 0, 0, 0, 1);
        send(4'd3,  32'h80000000, 32'h00000001, 5'd8,  32'h7FFFFFFF, 0, 1, 0, 1);
        send(4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 5'd9,  32'hF000F000, 1, 0, 0, 1);
        send(4'd5,  32'h0F0F0000, 32'h000000FF, 5'd10, 32'h0F0F00FF, 0, 0, 0, 1);
        send(4'd6,  32'hFFFF0000, 32'hFFFFFFFF, 5'd11, 32'h0000FFFF, 0, 0, 0, 1);
        send(4'd7,  32'h00000000, 32'h00000000, 5'd12, 32'hFFFFFFFF, 1, 0, 0, 1);
        send(4'd12, 32'h00000005, 32'h00000007, 5'd13, 32'h00000000, 0, 0, 1, 1);
        send(4'd2,  32'hFFFFFFFF, 32'h00000001, 5'd14, 32'h00000000, 0, 0, 1, 1);
        in_valid = 1'b0;
        repeat (5) @(posedge CLK); #1;

        // Backpressure: two ops fill the pipe, third must wait
        out_ready = 1'b0;
        send(4'd2, 32'd1, 32'd100, 5'd1, 32'd101, 0, 0, 0, 0);
        send(4'd2, 32'd2, 32'd100, 5'd2, 32'd102, 0, 0, 0, 0);
        aluop = 4'd2; port_a = 32'd3; port_b = 32'd100; in_tag = 5'd3; in_valid = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("in_ready_full", 64'(in_ready), 64'd0);
        end
        @(posedge CLK); #1;
        out_ready = 1'b1;
        send(4'd2, 32'd3, 32'd100, 5'd3, 32'd103, 0, 0, 0, 0);
        send(4'd2, 32'd4, 32'd100, 5'd4, 32'd104, 0, 0, 0, 0);
        in_valid = 1'b0;
        repeat (6) @(posedge CLK); #1;

        // Flush with a full pipe and a pending op
        out_ready = 1'b0;
        send(4'd2, 32'd9,  32'd100, 5'd9,  32'd109, 0, 0, 0, 0);
        send(4'd2, 32'd10, 32'd100, 5'd10, 32'd110, 0, 0, 0, 0);
        in_tag = 5'd11; in_valid = 1'b1; flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        // Flush with an empty pipe drops the op accepted in the flush cycle
        in_tag = 5'd12; in_valid = 1'b1; flush = 1'b1;
        @(negedge CLK);
        check("flush_empty_in_ready", 64'(in_ready), 64'd1);
        @(posedge CLK); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            check("flush_no_emerge", 64'(out_valid), 64'd0);
        end
        @(posedge CLK); #1;
        send(4'd6, 32'hAAAA5555, 32'h5555AAAA, 5'd13, 32'hFFFFFFFF, 1, 0, 0, 1);
        in_valid = 1'b0;
        repeat (4) @(posedge CLK); #1;

        // Asynchronous reset with two ops in flight
        send(4'd2, 32'd14, 32'd100, 5'd14, 32'd114, 0, 0, 0, 1);
        send(4'd2, 32'd15, 32'd100, 5'd15, 32'd115, 0, 0, 0, 1);
        in_valid = 1'b0;
        #1;
        nRST = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge CLK); #1;
        send(4'd9, 32'd0, 32'd1, 5'd16, 32'd1, 0, 0, 0, 1);
        in_valid = 1'b0;

        repeat (6) @(posedge CLK); #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
